// File: rtl/encaps_sequencer_if.sv
// Handshake and control bundle between the NTRU-HRSS encapsulation
// sequencer and the host / datapath it drives.
interface encaps_sequencer_if;
  logic       start;
  logic       abort;
  logic       rand_valid;
  logic       rand_ready;
  logic       busy;
  logic [2:0] phase;
  logic       unpack_en;
  logic       sample_en;
  logic       pack_clr;
  logic       pack_en;
  logic       hash_clr;
  logic       hash_absorb;
  logic       hash_round_en;
  logic [4:0] round_idx;
  logic       key_latch;
  logic       done;

  modport master (
    output start, abort, rand_valid,
    input  rand_ready, busy, phase, unpack_en, sample_en, pack_clr, pack_en,
           hash_clr, hash_absorb, hash_round_en, round_idx, key_latch, done
  );

  modport slave (
    input  start, abort, rand_valid,
    output rand_ready, busy, phase, unpack_en, sample_en, pack_clr, pack_en,
           hash_clr, hash_absorb, hash_round_en, round_idx, key_latch, done
  );
endinterface

// File: rtl/encaps_sequencer.sv
// Phase scheduler for NTRU-HRSS encapsulation: unpack, ternary sampling,
// pack_s3 and SHA3-256 absorb/keccak per rate block, then key latch.
module encaps_sequencer #(
  parameter int UNPACK_CYC    = 351,
  parameter int SAMPLE_CYC    = 176,
  parameter int PACK_CYC      = 68,
  parameter int HASH_BLOCKS   = 2,
  parameter int KECCAK_ROUNDS = 24
) (
  input logic               clk,
  input logic               rst,
  encaps_sequencer_if.slave bus
);
  localparam int BLK_W = (HASH_BLOCKS > 1) ? $clog2(HASH_BLOCKS) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
  localparam logic [2:0] SAMPLE = 3'd2;
  localparam logic [2:0] PACK   = 3'd3;
  localparam logic [2:0] ABSORB = 3'd4;
  localparam logic [2:0] KECCAK = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam logic [8:0]       UNPACK_LAST = 9'(UNPACK_CYC - 1);
  localparam logic [8:0]       SAMPLE_LAST = 9'(SAMPLE_CYC - 1);
  localparam logic [8:0]       PACK_LAST   = 9'(PACK_CYC);
  localparam logic [4:0]       RND_LAST    = 5'(KECCAK_ROUNDS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST    = BLK_W'(HASH_BLOCKS - 1);

  logic [2:0]       state_r, state_s;
  logic [8:0]       cyc_cnt_r, cyc_cnt_s;
  logic [BLK_W-1:0] blk_cnt_r, blk_cnt_s;
  logic [4:0]       rnd_cnt_r, rnd_cnt_s;

  // Next-state and counter update; abort overrides every transition.
  always_comb begin
    state_s   = state_r;
    cyc_cnt_s = cyc_cnt_r;
    blk_cnt_s = blk_cnt_r;
    rnd_cnt_s = rnd_cnt_r;
    if (state_r != IDLE && bus.abort) begin
      state_s   = IDLE;
      cyc_cnt_s = 9'd0;
      blk_cnt_s = '0;
      rnd_cnt_s = 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_s   = UNPACK;
            cyc_cnt_s = 9'd0;
            blk_cnt_s = '0;
            rnd_cnt_s = 5'd0;
          end else begin
            state_s = IDLE;
          end
        end
        UNPACK: begin
          if (cyc_cnt_r == UNPACK_LAST) begin
            state_s   = SAMPLE;
            cyc_cnt_s = 9'd0;
          end else begin
            cyc_cnt_s = cyc_cnt_r + 9'd1;
          end
        end
        SAMPLE: begin
          if (bus.rand_valid && cyc_cnt_r == SAMPLE_LAST) begin
            state_s   = PACK;
            cyc_cnt_s = 9'd0;
          end else if (bus.rand_valid) begin
            cyc_cnt_s = cyc_cnt_r + 9'd1;
          end else begin
            cyc_cnt_s = cyc_cnt_r;
          end
        end
        PACK: begin
          // cycle 0 clears the packer, cycles 1..PACK_CYC shift
          if (cyc_cnt_r == PACK_LAST) begin
            state_s   = ABSORB;
            cyc_cnt_s = 9'd0;
          end else begin
            cyc_cnt_s = cyc_cnt_r + 9'd1;
          end
        end
        ABSORB: begin
          state_s   = KECCAK;
          rnd_cnt_s = 5'd0;
        end
        KECCAK: begin
          if (rnd_cnt_r == RND_LAST && blk_cnt_r == BLK_LAST) begin
            state_s   = DONE;
            rnd_cnt_s = 5'd0;
            blk_cnt_s = '0;
          end else if (rnd_cnt_r == RND_LAST) begin
            state_s   = PACK;
            rnd_cnt_s = 5'd0;
            cyc_cnt_s = 9'd0;
            blk_cnt_s = blk_cnt_r + BLK_W'(1);
          end else begin
            rnd_cnt_s = rnd_cnt_r + 5'd1;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s   = IDLE;
          cyc_cnt_s = 9'd0;
          blk_cnt_s = '0;
          rnd_cnt_s = 5'd0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cyc_cnt_r <= 9'd0;
      blk_cnt_r <= '0;
      rnd_cnt_r <= 5'd0;
    end else begin
      state_r   <= state_s;
      cyc_cnt_r <= cyc_cnt_s;
      blk_cnt_r <= blk_cnt_s;
      rnd_cnt_r <= rnd_cnt_s;
    end
  end

  // Moore decode: every output derives only from registered state/counters
  // (sample_en additionally follows rand_valid while in SAMPLE).
  assign bus.phase         = state_r;
  assign bus.busy          = (state_r != IDLE);
  assign bus.unpack_en     = (state_r == UNPACK);
  assign bus.rand_ready    = (state_r == SAMPLE);
  assign bus.sample_en     = (state_r == SAMPLE) && bus.rand_valid;
  assign bus.pack_clr      = (state_r == PACK) && (cyc_cnt_r == 9'd0);
  assign bus.pack_en       = (state_r == PACK) && (cyc_cnt_r != 9'd0);
  assign bus.hash_absorb   = (state_r == ABSORB);
  assign bus.hash_clr      = (state_r == ABSORB) && (blk_cnt_r == '0);
  assign bus.hash_round_en = (state_r == KECCAK);
  assign bus.round_idx     = (state_r == KECCAK) ? rnd_cnt_r : 5'd0;
  assign bus.key_latch     = (state_r == DONE);
  assign bus.done          = (state_r == DONE);
endmodule

// File: tb/tb_encaps_sequencer.sv
// Scoreboard bench for encaps_sequencer: stimulus queues expected job
// statistics, a negedge monitor accumulates DUT activity and checks on done.
module tb_encaps_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  encaps_sequencer_if bus();
  encaps_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int cycles;
    int n_unpack;
    int n_sample;
    int n_pack;
    int n_round;
    int n_hclr;
    int n_absorb;
    int n_pclr;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic toggle_mode = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int outs_vec();
    return int'({bus.rand_ready, bus.busy, bus.unpack_en, bus.sample_en,
                 bus.pack_clr, bus.pack_en, bus.hash_clr, bus.hash_absorb,
                 bus.hash_round_en, bus.key_latch, bus.done,
                 bus.round_idx, bus.phase});
  endfunction

  function automatic exp_t job_exp(input int cycles);
    exp_t e;
    e.cycles   = cycles;
    e.n_unpack = 351;
    e.n_sample = 176;
    e.n_pack   = 136;
    e.n_round  = 48;
    e.n_hclr   = 1;
    e.n_absorb = 2;
    e.n_pclr   = 2;
    return e;
  endfunction

  // Random source: steady 1, or alternating 1,0,... from the first SAMPLE cycle.
  initial begin
    int samp_idx;
    samp_idx = 0;
    bus.rand_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!toggle_mode) begin
        bus.rand_valid = 1'b1;
        samp_idx = 0;
      end else if (bus.phase == 3'd2) begin
        bus.rand_valid = (samp_idx % 2 == 0);
        samp_idx++;
      end else begin
        bus.rand_valid = 1'b0;
        samp_idx = 0;
      end
    end
  end

  // Monitor: accumulate per-job activity and score it when done appears.
  initial begin
    int cyc, n_un, n_sa, n_pa, n_rd, n_hc, n_ab, n_pc, rcnt, viol, ridx_err, kl_err;
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    {cyc, n_un, n_sa, n_pa, n_rd, n_hc, n_ab, n_pc, rcnt, viol, ridx_err, kl_err} = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
      end else begin
        if (bus.busy && !prev_busy)
          {cyc, n_un, n_sa, n_pa, n_rd, n_hc, n_ab, n_pc, rcnt, viol, ridx_err, kl_err} = '0;
        if (bus.busy) cyc++;
        n_un += int'(bus.unpack_en);
        n_sa += int'(bus.sample_en);
        n_pa += int'(bus.pack_en);
        n_rd += int'(bus.hash_round_en);
        n_hc += int'(bus.hash_clr);
        n_ab += int'(bus.hash_absorb);
        n_pc += int'(bus.pack_clr);
        if (int'(bus.unpack_en) + int'(bus.sample_en) + int'(bus.pack_en) +
            int'(bus.hash_absorb) + int'(bus.hash_round_en) > 1) viol++;
        if (bus.hash_round_en) begin
          if (int'(bus.round_idx) != rcnt % 24) ridx_err++;
          rcnt++;
        end
        if (bus.key_latch != bus.done) kl_err++;
        if (bus.done) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
          end else begin
            e = sb_q.pop_front();
            check("done_latency", cyc, e.cycles);
            check("unpack_en_count", n_un, e.n_unpack);
            check("sample_en_count", n_sa, e.n_sample);
            check("pack_en_count", n_pa, e.n_pack);
            check("round_en_count", n_rd, e.n_round);
            check("hash_clr_count", n_hc, e.n_hclr);
            check("absorb_count", n_ab, e.n_absorb);
            check("pack_clr_count", n_pc, e.n_pclr);
            check("enable_overlap", viol, 0);
            check("round_idx_seq", ridx_err, 0);
            check("key_latch_vs_done", kl_err, 0);
          end
        end
        prev_busy = bus.busy;
      end
    end
  end

  task automatic start_job(input bit expect_done, input int cycles);
    @(negedge clk);
    if (expect_done) sb_q.push_back(job_exp(cycles));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!bus.done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_phase(input string name, input logic [2:0] ph,
                            input int ridx, input int bound);
    int n;
    n = 0;
    while (!(bus.phase == ph && (ridx < 0 || int'(bus.round_idx) == ridx)) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=phase%0d expected=phase%0d", name, bus.phase, ph);
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    rst = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_in_idle_busy", int'(bus.busy), 0);

    // Job 1: steady random source.
    start_job(1'b1, 716);
    wait_done("job1", 2000);
    @(negedge clk);
    check("job1_idle_after", int'(bus.phase), 0);

    // Job 2: alternating random source stretches SAMPLE to 351 cycles.
    toggle_mode = 1'b1;
    begin
      exp_t e;
      e = job_exp(891);
      @(negedge clk);
      sb_q.push_back(e);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_done("job2", 2000);
    @(negedge clk);
    toggle_mode = 1'b0;

    // Job 3: abort during round 10 of block 0.
    start_job(1'b0, 0);
    wait_phase("job3_round10", 3'd5, 10, 2000);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_phase", int'(bus.phase), 0);
    check("abort_done", int'(bus.done), 0);
    repeat (20) @(negedge clk);

    // Job 4: normal completion after abort.
    start_job(1'b1, 716);
    wait_done("job4", 2000);
    @(negedge clk);

    // Job 5: start pulses during UNPACK and during DONE are ignored.
    start_job(1'b1, 716);
    repeat (4) @(negedge clk);
    check("unpack_phase", int'(bus.phase), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("job5", 2000);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_in_done_busy", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    check("start_in_done_phase", int'(bus.phase), 0);

    // Job 6: asynchronous reset mid-SAMPLE, then a fresh job.
    start_job(1'b1, 716);
    wait_phase("job6_sample", 3'd2, -1, 2000);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", outs_vec(), 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(bus.busy), 0);
    start_job(1'b1, 716);
    wait_done("job7", 2000);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/encaps_sequencer.md
Name: encaps_sequencer

Overview:
- Top-level phase scheduler for the NTRU-HRSS encapsulation datapath.
- Runs one job per `start` pulse, in this order: public-key unpack, ternary sampling of r/m, pack_s3, then SHA3-256 absorb/keccak per rate block.
- Generates all per-phase enables and clears, tracks cycle, block and round counts, and throttles sampling against the random-bit source.
- Pulses `key_latch` and `done` when the shared secret is ready.

Parameters:
- UNPACK_CYC, 351, cycles of unpack_rq0 enable (two 13-bit coefficients per cycle).
- SAMPLE_CYC, 176, random words the ternary sampler must accept.
- PACK_CYC, 68, pack_s3 shift cycles per 1088-bit rate block.
- HASH_BLOCKS, 2, rate blocks absorbed by SHA3-256.
- KECCAK_ROUNDS, 24, keccak-f rounds per block.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current job.
- rand_valid  in  1  random word available on the sampler bits bus.
- rand_ready  out  1  sequencer accepts a random word this cycle.
- busy  out  1  high in every state except IDLE.
- phase  out  3  current state encoding.
- unpack_en  out  1  unpack_rq0 SIPO shift enable.
- sample_en  out  1  ternary SIPO shift enable.
- pack_clr  out  1  pack_s3 block clear.
- pack_en  out  1  pack_s3 shift enable.
- hash_clr  out  1  clear sponge state (first block only).
- hash_absorb  out  1  XOR packed block into sponge.
- hash_round_en  out  1  execute one keccak round.
- round_idx  out  5  keccak round index.
- key_latch  out  1  capture hash output into k.
- done  out  1  job complete, one-cycle pulse.

Behaviour:
- Reset (async): state IDLE, all counters 0, every output 0, phase=0.
- State encoding: IDLE=0, UNPACK=1, SAMPLE=2, PACK=3, ABSORB=4, KECCAK=5, DONE=6.
- Outputs are Moore, decoded from registered state and counters.
- Counters:
  - cyc_cnt: 9 bits.
  - blk_cnt: width sufficient for HASH_BLOCKS.
  - rnd_cnt: 5 bits.
- IDLE:
  - start=1 moves to UNPACK; cyc_cnt and blk_cnt are set to 0.
  - start is ignored in every other state; no queuing.
- UNPACK:
  - unpack_en=1 every cycle; cyc_cnt increments.
  - After UNPACK_CYC cycles, go to SAMPLE with cyc_cnt=0.
- SAMPLE:
  - rand_ready=1 throughout.
  - sample_en = rand_valid; cyc_cnt increments only on rand_valid.
  - The cycle that accepts word SAMPLE_CYC goes to PACK.
  - rand_valid=0 stalls indefinitely; there is no timeout.
- PACK:
  - First cycle: pack_clr=1, pack_en=0.
  - Next PACK_CYC cycles: pack_en=1.
  - Total PACK_CYC+1 cycles, then ABSORB.
- ABSORB:
  - Single cycle with hash_absorb=1.
  - hash_clr=1 in the same cycle only when blk_cnt=0.
  - Next state KECCAK with rnd_cnt=0.
- KECCAK:
  - hash_round_en=1 and round_idx=rnd_cnt each cycle.
  - After round KECCAK_ROUNDS-1: if blk_cnt=HASH_BLOCKS-1 go to DONE; otherwise increment blk_cnt and return to PACK.
- DONE:
  - One cycle with key_latch=1 and done=1.
  - Next state IDLE. start in this cycle is ignored.
- abort=1 in any non-IDLE state:
  - Next state IDLE; counters cleared; done and key_latch are not pulsed.
  - abort has priority over all transitions, including the DONE exit. abort in IDLE has no effect.
- Mutual exclusion: at most one of unpack_en, sample_en, pack_en, hash_absorb, hash_round_en is high in any cycle.
- Latency with rand_valid held at 1:
  - Cycles from the start edge to done = 1 + UNPACK_CYC + SAMPLE_CYC + HASH_BLOCKS*(PACK_CYC+2+KECCAK_ROUNDS).
  - With defaults: 1+351+176+2*94 = 716.
- Wrap-around: counters never exceed their terminal value; each is reloaded to 0 on the phase exit.

Test Plan:
- Reset then start=1 for one cycle, rand_valid=1 constant -> done pulses exactly 716 cycles after the start edge.
  - unpack_en high for 351 cycles, sample_en for 176, pack_en for 136, hash_round_en for 48, key_latch coincident with done.
- Same job with rand_valid toggling 1,0,1,0 -> exactly 176 sample_en pulses; SAMPLE lasts 351 cycles; done arrives at cycle 891.
- Block sequencing -> hash_clr asserted only in the first ABSORB; round_idx runs 0..23 twice; no cycle has two enables high.
- abort asserted in KECCAK round 10 of block 0 -> IDLE next cycle, busy=0, no done.
  - A following start then completes normally in 716 cycles.
- start pulses during UNPACK and in the DONE cycle -> ignored; only one done per accepted start.
- rst asserted mid-SAMPLE (asynchronously, between edges) -> all outputs 0 immediately, phase=0; after release, start behaves as from power-up.
